// File: rtl/dram_pkg.sv
// dram_pkg: address widths and command encoding shared by the DRAM controller blocks
package dram_pkg;
  localparam int BANK_GROUP_BITS = 2;
  localparam int BANK_BITS       = 2;
  localparam int ROW_BITS        = 16;
  localparam int COLUMN_BITS     = 10;
  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_e;
endpackage

// File: rtl/dram_cmd_fsm.sv
// dram_cmd_fsm: per-request PRE/ACT/RD/WR sequencer with periodic all-bank refresh
module dram_cmd_fsm
  import dram_pkg::*;
#(
  parameter int tRP   = 3,
  parameter int tRCD  = 4,
  parameter int tCL   = 5,
  parameter int tWR   = 6,
  parameter int tRFC  = 10,
  parameter int tREFI = 7800
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [BANK_GROUP_BITS-1:0] req_bg,
  input  logic [BANK_BITS-1:0]       req_bank,
  input  logic [ROW_BITS-1:0]        req_row,
  input  logic [COLUMN_BITS-1:0]     req_col,
  input  logic [1:0]                 row_stat,
  output logic                       pol_req_en,
  output logic [BANK_GROUP_BITS-1:0] lk_bg,
  output logic [BANK_BITS-1:0]       lk_bank,
  output logic [ROW_BITS-1:0]        lk_row,
  output logic                       row_resolve,
  output logic                       tACT_done,
  output logic                       tREF_done,
  output logic [2:0]                 cmd,
  output logic [BANK_GROUP_BITS-1:0] cmd_bg,
  output logic [BANK_BITS-1:0]       cmd_bank,
  output logic [ROW_BITS-1:0]        cmd_row,
  output logic [COLUMN_BITS-1:0]     cmd_col,
  output logic                       resp_valid,
  output logic                       resp_write
);
  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_PRE_W, S_ACT_W, S_RW_W, S_RPRE_W, S_REF_W
  } state_e;
  localparam logic [7:0]  RP_M1   = 8'(tRP - 1);
  localparam logic [7:0]  RCD_M1  = 8'(tRCD - 1);
  localparam logic [7:0]  RFC_M1  = 8'(tRFC - 1);
  localparam logic [15:0] REFI_M1 = 16'(tREFI - 1);
  state_e                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [15:0]                ref_cnt_q, ref_cnt_d;
  logic                       ref_pend_q, ref_pend_d;
  logic                       wr_q, wr_d;
  logic [BANK_GROUP_BITS-1:0] bg_q, bg_d;
  logic [BANK_BITS-1:0]       bank_q, bank_d;
  logic [ROW_BITS-1:0]        row_q, row_d;
  logic [COLUMN_BITS-1:0]     col_q, col_d;
  logic                       resp_valid_q, resp_valid_d;
  logic                       resp_write_q, resp_write_d;
  logic                       tref_done_q, tref_done_d;
  logic                       go_rw;
  logic [7:0]                 rw_lat;
  cmd_e                       cmd_n;
  assign req_ready  = (state_q == S_IDLE) && !ref_pend_q;
  assign pol_req_en = state_q inside {S_DECIDE, S_PRE_W, S_ACT_W, S_RW_W};
  assign lk_bg      = bg_q;
  assign lk_bank    = bank_q;
  assign lk_row     = row_q;
  assign rw_lat     = wr_q ? 8'(tWR) : 8'(tCL);
  assign cmd        = cmd_n;
  assign cmd_bg     = (cmd_n inside {CMD_ACT, CMD_RD, CMD_WR, CMD_PRE}) ? bg_q : '0;
  assign cmd_bank   = (cmd_n inside {CMD_ACT, CMD_RD, CMD_WR, CMD_PRE}) ? bank_q : '0;
  assign cmd_row    = (cmd_n == CMD_ACT) ? row_q : '0;
  assign cmd_col    = (cmd_n inside {CMD_RD, CMD_WR}) ? col_q : '0;
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign tREF_done  = tref_done_q;
  // Next-state, command issue and wait-counter control; commands are decoded in the cycle they issue
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
    ref_cnt_d    = (ref_cnt_q == REFI_M1) ? 16'd0 : ref_cnt_q + 16'd1;
    ref_pend_d   = tref_done_q ? 1'b0 : (ref_pend_q || ref_cnt_q == REFI_M1);
    wr_d         = wr_q;
    bg_d         = bg_q;
    bank_d       = bank_q;
    row_d        = row_q;
    col_d        = col_q;
    resp_valid_d = 1'b0;
    resp_write_d = 1'b0;
    tref_done_d  = 1'b0;
    cmd_n        = CMD_NOP;
    row_resolve  = 1'b0;
    tACT_done    = 1'b0;
    go_rw        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ref_pend_q && !tref_done_q) begin
          cmd_n   = CMD_PREA;
          cnt_d   = RP_M1;
          state_d = S_RPRE_W;
        end else if (req_valid && req_ready) begin
          wr_d    = req_write;
          bg_d    = req_bg;
          bank_d  = req_bank;
          row_d   = req_row;
          col_d   = req_col;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        unique case (row_stat)
          2'b01: go_rw = 1'b1;
          2'b10: begin
            cmd_n   = CMD_ACT;
            cnt_d   = RCD_M1;
            state_d = S_ACT_W;
          end
          2'b11: begin
            cmd_n   = CMD_PRE;
            cnt_d   = RP_M1;
            state_d = S_PRE_W;
          end
          default: cmd_n = CMD_NOP;
        endcase
      end
      S_PRE_W: begin
        if (cnt_q == 8'd0) begin
          cmd_n       = CMD_ACT;
          row_resolve = 1'b1;
          cnt_d       = RCD_M1;
          state_d     = S_ACT_W;
        end
      end
      S_ACT_W: begin
        if (cnt_q == 8'd0) begin
          go_rw     = 1'b1;
          tACT_done = 1'b1;
        end
      end
      S_RW_W: begin
        if (cnt_q == 8'd1) begin
          resp_valid_d = 1'b1;
          resp_write_d = wr_q;
          state_d      = S_IDLE;
        end
      end
      S_RPRE_W: begin
        if (cnt_q == 8'd0) begin
          cmd_n       = CMD_REF;
          cnt_d       = RFC_M1;
          tref_done_d = (RFC_M1 == 8'd0);
          state_d     = (RFC_M1 == 8'd0) ? S_IDLE : S_REF_W;
        end
      end
      S_REF_W: begin
        if (cnt_q == 8'd1) begin
          tref_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_rw) begin
      cmd_n        = wr_q ? CMD_WR : CMD_RD;
      cnt_d        = rw_lat - 8'd1;
      resp_valid_d = (rw_lat == 8'd1);
      resp_write_d = (rw_lat == 8'd1) && wr_q;
      state_d      = (rw_lat == 8'd1) ? S_IDLE : S_RW_W;
    end
  end
  // State, counters, latched request and registered completion strobes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ref_cnt_q    <= '0;
      ref_pend_q   <= 1'b0;
      wr_q         <= 1'b0;
      bg_q         <= '0;
      bank_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      tref_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      wr_q         <= wr_d;
      bg_q         <= bg_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      col_q        <= col_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      tref_done_q  <= tref_done_d;
    end
  end
endmodule

// File: tb/tb_dram_cmd_fsm.sv
// tb_dram_cmd_fsm: directed scenario checks of the DRAM command sequencer
module tb_dram_cmd_fsm;
  import dram_pkg::*;
  logic                       CLK;
  logic                       nRST;
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [BANK_GROUP_BITS-1:0] req_bg;
  logic [BANK_BITS-1:0]       req_bank;
  logic [ROW_BITS-1:0]        req_row;
  logic [COLUMN_BITS-1:0]     req_col;
  logic [1:0]                 row_stat;
  logic                       pol_req_en;
  logic [BANK_GROUP_BITS-1:0] lk_bg;
  logic [BANK_BITS-1:0]       lk_bank;
  logic [ROW_BITS-1:0]        lk_row;
  logic                       row_resolve;
  logic                       tACT_done;
  logic                       tREF_done;
  logic [2:0]                 cmd;
  logic [BANK_GROUP_BITS-1:0] cmd_bg;
  logic [BANK_BITS-1:0]       cmd_bank;
  logic [ROW_BITS-1:0]        cmd_row;
  logic [COLUMN_BITS-1:0]     cmd_col;
  logic                       resp_valid;
  logic                       resp_write;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  dram_cmd_fsm #(
    .tRP(3), .tRCD(4), .tCL(5), .tWR(6), .tRFC(10), .tREFI(64)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .row_stat(row_stat), .pol_req_en(pol_req_en),
    .lk_bg(lk_bg), .lk_bank(lk_bank), .lk_row(lk_row),
    .row_resolve(row_resolve), .tACT_done(tACT_done), .tREF_done(tREF_done),
    .cmd(cmd), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .resp_valid(resp_valid), .resp_write(resp_write)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask
  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask
  task automatic do_reset();
    nRST      = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    row_stat  = 2'b00;
    req_bg    = 2'd1;
    req_bank  = 2'd2;
    req_row   = 16'h1234;
    req_col   = 10'h055;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cyc  = 0;
  endtask
  task automatic test_reset();
    logic [6:0] obs;
    nRST      = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    row_stat  = 2'b01;
    req_bg    = 2'd3;
    req_bank  = 2'd3;
    req_row   = 16'hffff;
    req_col   = 10'h3ff;
    @(posedge CLK);
    #2;
    obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
    compared++;
    if (obs !== 7'd0 || pol_req_en !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h/%b exp=00/0", obs, pol_req_en);
    end
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
    compared++;
    if ({cmd_bg, cmd_bank, cmd_row, cmd_col} !== '0) begin
      mismatched++;
      $display("FAIL reset_cmd_addr got=%h exp=0", {cmd_bg, cmd_bank, cmd_row, cmd_col});
    end
  endtask
  task automatic test_hit_read();
    logic [6:0] obs, exp;
    do_reset();
    run_to(10);
    req_valid = 1'b1;
    req_write = 1'b0;
    row_stat  = 2'b01;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL hit_ready_at_10 got=%b exp=1", req_ready);
    end
    for (int c = 11; c <= 23; c++) begin
      step();
      req_valid = (cyc == 16);
      req_write = (cyc == 16);
      #1;
      obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
      exp = {(cyc == 11) ? 3'd2 : (cyc == 17) ? 3'd3 : 3'd0, 2'b00, (cyc == 16 || cyc == 23), 1'b0};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL hit_seq cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      if (cyc == 11) begin
        compared++;
        if ({cmd_bg, cmd_bank, cmd_col} !== {2'd1, 2'd2, 10'h055} || pol_req_en !== 1'b1) begin
          mismatched++;
          $display("FAIL hit_rd_addr got=%h/%b exp=%h/1", {cmd_bg, cmd_bank, cmd_col}, pol_req_en, {2'd1, 2'd2, 10'h055});
        end
      end
      if (cyc == 16) begin
        compared++;
        if (resp_write !== 1'b0 || req_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL hit_resp16 got=wr%b/rdy%b exp=wr0/rdy1", resp_write, req_ready);
        end
      end
      if (cyc == 23) begin
        compared++;
        if (resp_write !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_resp_write got=%b exp=1", resp_write);
        end
      end
    end
  endtask
  task automatic test_miss_read();
    logic [6:0] obs, exp;
    do_reset();
    run_to(10);
    req_valid = 1'b1;
    req_write = 1'b0;
    row_stat  = 2'b10;
    for (int c = 11; c <= 21; c++) begin
      step();
      req_valid = 1'b0;
      #1;
      obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
      exp = {(cyc == 11) ? 3'd1 : (cyc == 15) ? 3'd2 : 3'd0, 1'b0, (cyc == 15), (cyc == 20), 1'b0};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL miss_seq cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      if (cyc == 11) begin
        compared++;
        if ({cmd_bg, cmd_bank, cmd_row} !== {2'd1, 2'd2, 16'h1234}) begin
          mismatched++;
          $display("FAIL miss_act_addr got=%h exp=%h", {cmd_bg, cmd_bank, cmd_row}, {2'd1, 2'd2, 16'h1234});
        end
      end
    end
  endtask
  task automatic test_conflict_write();
    logic [6:0] obs, exp;
    do_reset();
    req_bg   = 2'd2;
    req_bank = 2'd1;
    req_row  = 16'hbeef;
    req_col  = 10'h2a3;
    run_to(10);
    req_valid = 1'b1;
    req_write = 1'b1;
    row_stat  = 2'b11;
    for (int c = 11; c <= 25; c++) begin
      step();
      req_valid = 1'b0;
      #1;
      obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
      exp = {(cyc == 11) ? 3'd4 : (cyc == 14) ? 3'd1 : (cyc == 18) ? 3'd3 : 3'd0,
             (cyc == 14), (cyc == 18), (cyc == 24), 1'b0};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL conflict_seq cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      if (cyc == 11 || cyc == 14 || cyc == 18) begin
        compared++;
        if ({cmd_bg, cmd_bank} !== {2'd2, 2'd1}) begin
          mismatched++;
          $display("FAIL conflict_bank cyc=%0d got=%h exp=%h", cyc, {cmd_bg, cmd_bank}, {2'd2, 2'd1});
        end
      end
      if (cyc == 14) begin
        compared++;
        if (cmd_row !== 16'hbeef) begin
          mismatched++;
          $display("FAIL conflict_act_row got=%h exp=beef", cmd_row);
        end
      end
      if (cyc == 18) begin
        compared++;
        if (cmd_col !== 10'h2a3) begin
          mismatched++;
          $display("FAIL conflict_wr_col got=%h exp=2a3", cmd_col);
        end
      end
      if (cyc == 24) begin
        compared++;
        if (resp_write !== 1'b1) begin
          mismatched++;
          $display("FAIL conflict_resp_write got=%b exp=1", resp_write);
        end
      end
    end
  endtask
  task automatic test_refresh();
    logic [6:0] obs, exp;
    logic       exp_rdy;
    do_reset();
    row_stat = 2'b01;
    for (int c = 1; c <= 79; c++) begin
      step();
      req_valid = (cyc >= 64 && cyc <= 78);
      #1;
      obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
      exp = {(cyc == 64) ? 3'd5 : (cyc == 67) ? 3'd6 : (cyc == 79) ? 3'd2 : 3'd0, 3'b000, (cyc == 77)};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL refresh_seq cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      exp_rdy = (cyc < 64 || cyc == 78);
      compared++;
      if (req_ready !== exp_rdy) begin
        mismatched++;
        $display("FAIL refresh_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
      end
      if (cyc >= 64 && cyc <= 78) begin
        compared++;
        if (pol_req_en !== 1'b0) begin
          mismatched++;
          $display("FAIL refresh_pol_en cyc=%0d got=%b exp=0", cyc, pol_req_en);
        end
      end
    end
  endtask
  task automatic test_stall();
    logic [6:0] obs, exp;
    do_reset();
    run_to(10);
    req_valid = 1'b1;
    req_write = 1'b0;
    row_stat  = 2'b00;
    for (int c = 11; c <= 19; c++) begin
      step();
      req_valid = 1'b0;
      row_stat  = (cyc >= 14) ? 2'b01 : 2'b00;
      #1;
      obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
      exp = {(cyc == 14) ? 3'd2 : 3'd0, 3'b000, 1'b0} | {6'd0, 1'b0} | ((cyc == 19) ? 7'b0000010 : 7'd0);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL stall_seq cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      if (cyc <= 13) begin
        compared++;
        if (pol_req_en !== 1'b1 || {cmd_bg, cmd_bank, cmd_row, cmd_col} !== '0) begin
          mismatched++;
          $display("FAIL stall_decide cyc=%0d got=%b/%h exp=1/0", cyc, pol_req_en, {cmd_bg, cmd_bank, cmd_row, cmd_col});
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [6:0] obs, exp;
    do_reset();
    run_to(10);
    req_valid = 1'b1;
    req_write = 1'b1;
    row_stat  = 2'b10;
    step();
    req_valid = 1'b0;
    #1;
    compared++;
    if (cmd !== 3'd1) begin
      mismatched++;
      $display("FAIL rstmid_act got=%0d exp=1", cmd);
    end
    run_to(13);
    compared++;
    if (pol_req_en !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_in_actw got=%b exp=1", pol_req_en);
    end
    nRST = 1'b0;
    #1;
    obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
    compared++;
    if (obs !== 7'd0 || pol_req_en !== 1'b0 || req_ready !== 1'b1 || {cmd_bg, cmd_bank, cmd_row, cmd_col} !== '0) begin
      mismatched++;
      $display("FAIL rstmid_immediate got=%h/%b/%b exp=00/0/1", obs, pol_req_en, req_ready);
    end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cyc  = 0;
    row_stat = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      step();
      #1;
      obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
      compared++;
      if (obs !== 7'd0 || req_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL rstmid_quiet cyc=%0d got=%h/%b exp=00/1", cyc, obs, req_ready);
      end
    end
    run_to(6);
    req_valid = 1'b1;
    req_write = 1'b0;
    step();
    req_valid = 1'b0;
    #1;
    exp = {3'd2, 4'b0000};
    obs = {cmd, row_resolve, tACT_done, resp_valid, tREF_done};
    compared++;
    if (obs !== exp || pol_req_en !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_next_req got=%h/%b exp=%h/1", obs, pol_req_en, exp);
    end
  endtask
  initial begin
    test_reset();
    test_hit_read();
    test_miss_read();
    test_conflict_write();
    test_refresh();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dram_cmd_fsm.md
# dram_cmd_fsm

Per-request DRAM command sequencer that sits directly downstream of the open-row policy table. It accepts one decoded memory request at a time and presents its bank/row to the policy as a lookup. From the returned row status (HIT/MISS/CONFLICT) it issues the PRE/ACT/RD/WR command sequence with tRP/tRCD/tCL/tWR spacing. It drives the policy's bookkeeping strobes (row_resolve, tACT_done, tREF_done) and owns the periodic all-bank refresh sequence.

## Interface
Parameters (all timings in CLK cycles; each timing value must be between 1 and 255):
- tRP, 3: PRE/PREA to next command.
- tRCD, 4: ACT to RD/WR.
- tCL, 5: RD to resp_valid.
- tWR, 6: WR to resp_valid.
- tRFC, 10: REF to tREF_done.
- tREFI, 7800: refresh interval, 2 to 65535.

Widths BG/BK/ROW/COL are BANK_GROUP_BITS/BANK_BITS/ROW_BITS/COLUMN_BITS from dram_pkg.

Ports:
- CLK in 1: single clock, rising edge.
- nRST in 1: reset, asynchronous, active-low.
- req_valid in 1: request offered.
- req_ready out 1: request accepted when req_valid && req_ready.
- req_write in 1: 1 = write, 0 = read.
- req_bg, req_bank, req_row, req_col in BG/BK/ROW/COL: request address.
- row_stat in 2: from policy. 00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT.
- pol_req_en out 1: policy req_en.
- lk_bg, lk_bank, lk_row out BG/BK/ROW: lookup address to policy, equal to the latched request.
- row_resolve out 1: one-cycle strobe to policy.
- tACT_done out 1: one-cycle strobe to policy.
- tREF_done out 1: one-cycle strobe to policy.
- cmd out 3: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF.
- cmd_bg, cmd_bank, cmd_row, cmd_col out BG/BK/ROW/COL: command address, valid when cmd != NOP, otherwise 0.
- resp_valid out 1: one-cycle completion pulse.
- resp_write out 1: type of the completed request, valid with resp_valid.

## Operation
- States: IDLE, DECIDE, PRE_W, ACT_W, RW_W, RPRE_W, REF_W.
- Latched request registers (write flag, bg, bank, row, col) load on acceptance.
- req_ready = (state == IDLE) && !ref_pending. It is combinational.
- pol_req_en = 1 in every non-IDLE state except RPRE_W and REF_W. lk_* always drive the latched registers.
- Wait counter is 8 bits, loaded with (param − 1) when a command issues, and decremented each cycle. The wait state exits in the cycle after the counter reaches 0, i.e. the next command issues exactly param cycles after the previous one.
- IDLE:
  - ref_pending → issue PREA, go to RPRE_W. Refresh has priority over a simultaneous req_valid.
  - Else on acceptance → DECIDE.
- DECIDE samples row_stat and issues in the same cycle:
  - HIT → RD or WR, go to RW_W.
  - MISS → ACT at the latched bg/bank/row, go to ACT_W.
  - CONFLICT → PRE at the latched bg/bank, go to PRE_W.
  - IDLE (00) → NOP, stay in DECIDE.
- PRE_W end: issue ACT, assert row_resolve in that same cycle, go to ACT_W.
- ACT_W end: issue RD/WR, assert tACT_done in that same cycle, go to RW_W.
- RW_W: wait tCL (read) or tWR (write). On expiry, resp_valid = 1 and resp_write = latched flag for one cycle, with state = IDLE in that same cycle.
- Refresh counter is 16 bits, free-running from reset. When it equals tREFI−1 it wraps to 0 and sets sticky ref_pending. Further wraps while already pending are not queued.
- RPRE_W end: issue REF, go to REF_W.
- REF_W expiry: tREF_done = 1 for one cycle, state = IDLE in that same cycle, and ref_pending clears on that edge.
- An in-flight request always completes before a refresh starts.

## Timing
- Reset (async, immediate, including mid-sequence):
  - State = IDLE, counters = 0, ref_pending = 0.
  - cmd = NOP and cmd_* = 0.
  - pol_req_en, row_resolve, tACT_done, tREF_done and resp_valid = 0.
  - req_ready = 1.
  - No partial command is emitted after reset.
- Accept at cycle A. First command at A+1 when row_stat ≠ 00.
- HIT read: RD at A+1, resp at A+1+tCL.
- MISS: ACT at A+1, RD/WR at A+1+tRCD.
- CONFLICT: PRE at A+1, ACT at A+1+tRP, RD/WR at A+1+tRP+tRCD.
- Refresh beginning at R: PREA at R, REF at R+tRP, tREF_done at R+tRP+tRFC, req_ready at R+tRP+tRFC+1.
- At most one command per cycle. All strobes are exactly one cycle wide.

## Test plan
Parameters for all scenarios: tRP=3, tRCD=4, tCL=5, tWR=6, tRFC=10, tREFI=64.
- Read HIT, accepted at cycle 10 → RD at 11, resp_valid at 16 with resp_write = 0, req_ready = 1 at 16.
- Read MISS at 10 → ACT at 11, then RD with tACT_done at 15, resp_valid at 20. No row_resolve is asserted.
- Write CONFLICT at 10 → PRE at 11, then ACT with row_resolve at 14, then WR with tACT_done at 18, resp_valid with resp_write = 1 at 24.
- Refresh from reset with no traffic → ref_pending after cycle 63, PREA at 64, REF at 67, tREF_done at 77, req_ready = 1 at 78. A req_valid held during 64–77 is not accepted until 78.
- row_stat = 00 for 3 cycles in DECIDE → cmd = NOP for those cycles, then the correct command issues once HIT arrives.
- nRST asserted during ACT_W → all outputs return to reset values immediately, no RD is issued, and the next request starts from DECIDE.
